// File: rtl/trigger_delay_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : trigger_delay_sweep_ctrl_pkg
// Brief  : Shared sweep state encoding, command codes and status bit positions.
// Rev    : 1.0
// ============================================================================
package trigger_delay_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HOLDOFF = 2'd2
  } sweep_state_t;

  // Command codes decoded by the UART command FSM.
  localparam logic [7:0] CMD_SWEEP_CFG    = 8'h20;
  localparam logic [7:0] CMD_SWEEP_START  = 8'h21;
  localparam logic [7:0] CMD_SWEEP_ABORT  = 8'h22;
  localparam logic [7:0] CMD_SWEEP_STATUS = 8'h23;

  // Status byte bit positions.
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

endpackage
`default_nettype wire

// File: rtl/trigger_delay_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module : trigger_delay_sweep_ctrl
// Brief  : Steps the trigger delay across a programmed range, advancing after
//          a set number of counted delayed-trigger fires per step.
// Rev    : 1.0
// ============================================================================
module trigger_delay_sweep_ctrl #(
  parameter int DELAY_W  = 32,
  parameter int REPEAT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DELAY_W-1:0]  cfg_start,
  input  logic [DELAY_W-1:0]  cfg_stop,
  input  logic [DELAY_W-1:0]  cfg_step,
  input  logic [REPEAT_W-1:0] cfg_repeat,
  input  logic [REPEAT_W-1:0] cfg_holdoff,
  input  logic                start,
  input  logic                abort,
  input  logic                trig_fired,
  output logic [DELAY_W-1:0]  delay_cycles,
  output logic                delay_update,
  output logic                busy,
  output logic                done,
  output logic                cfg_error,
  output logic [REPEAT_W-1:0] step_index
);
  import trigger_delay_sweep_ctrl_pkg::*;

  sweep_state_t        state_q, state_d;
  logic [DELAY_W-1:0]  delay_q, delay_d;
  logic                update_q, update_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [REPEAT_W-1:0] step_idx_q, step_idx_d;
  logic [REPEAT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [REPEAT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [DELAY_W-1:0]  stop_sh_q, stop_sh_d;
  logic [DELAY_W-1:0]  step_sh_q, step_sh_d;
  logic [REPEAT_W-1:0] rep_sh_q, rep_sh_d;
  logic [REPEAT_W-1:0] hold_sh_q, hold_sh_d;

  logic [DELAY_W:0]    next_w;
  logic [REPEAT_W-1:0] rep_max_w;
  logic [REPEAT_W-1:0] rep_inc_w;

  always_comb begin
    state_d    = state_q;
    delay_d    = delay_q;
    update_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    step_idx_d = step_idx_q;
    rep_cnt_d  = rep_cnt_q;
    hold_cnt_d = hold_cnt_q;
    stop_sh_d  = stop_sh_q;
    step_sh_d  = step_sh_q;
    rep_sh_d   = rep_sh_q;
    hold_sh_d  = hold_sh_q;

    // Extra bit catches wrap past the top of the delay range.
    next_w    = {1'b0, delay_q} + {1'b0, step_sh_q};
    rep_max_w = (rep_sh_q == '0) ? {{(REPEAT_W-1){1'b0}}, 1'b1} : rep_sh_q;
    rep_inc_w = rep_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!abort && start) begin
          if ((cfg_step == '0) || (cfg_start > cfg_stop)) begin
            err_d = 1'b1;
          end else begin
            stop_sh_d  = cfg_stop;
            step_sh_d  = cfg_step;
            rep_sh_d   = cfg_repeat;
            hold_sh_d  = cfg_holdoff;
            delay_d    = cfg_start;
            update_d   = 1'b1;
            step_idx_d = {{(REPEAT_W-1){1'b0}}, 1'b1};
            rep_cnt_d  = '0;
            hold_cnt_d = '0;
            state_d    = ST_ARMED;
          end
        end
      end
      ST_ARMED: begin
        if (abort) begin
          rep_cnt_d = '0;
          state_d   = ST_IDLE;
        end else if (trig_fired) begin
          if (rep_inc_w < rep_max_w) begin
            rep_cnt_d = rep_inc_w;
            if (hold_sh_q != '0) begin
              hold_cnt_d = hold_sh_q;
              state_d    = ST_HOLDOFF;
            end
          end else begin
            rep_cnt_d = '0;
            if (next_w[DELAY_W] || (next_w[DELAY_W-1:0] > stop_sh_q)) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              delay_d    = next_w[DELAY_W-1:0];
              update_d   = 1'b1;
              step_idx_d = step_idx_q + 1'b1;
              if (hold_sh_q != '0) begin
                hold_cnt_d = hold_sh_q;
                state_d    = ST_HOLDOFF;
              end
            end
          end
        end
      end
      ST_HOLDOFF: begin
        if (abort) begin
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
          state_d    = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
          if (hold_cnt_q == {{(REPEAT_W-1){1'b0}}, 1'b1}) begin
            state_d = ST_ARMED;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      delay_q    <= '0;
      update_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      step_idx_q <= '0;
      rep_cnt_q  <= '0;
      hold_cnt_q <= '0;
      stop_sh_q  <= '0;
      step_sh_q  <= '0;
      rep_sh_q   <= '0;
      hold_sh_q  <= '0;
    end else begin
      state_q    <= state_d;
      delay_q    <= delay_d;
      update_q   <= update_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      step_idx_q <= step_idx_d;
      rep_cnt_q  <= rep_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      stop_sh_q  <= stop_sh_d;
      step_sh_q  <= step_sh_d;
      rep_sh_q   <= rep_sh_d;
      hold_sh_q  <= hold_sh_d;
    end
  end

  assign delay_cycles = delay_q;
  assign delay_update = update_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_error    = err_q;
  assign step_index   = step_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_trigger_delay_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_trigger_delay_sweep_ctrl
// Brief  : Directed self-checking bench for trigger_delay_sweep_ctrl.
// Rev    : 1.0
// ============================================================================
module tb_trigger_delay_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_start, cfg_stop, cfg_step;
  logic [15:0] cfg_repeat, cfg_holdoff;
  logic        start, abort, trig_fired;
  logic [31:0] delay_cycles;
  logic        delay_update, busy, done, cfg_error;
  logic [15:0] step_index;

  int checks = 0;
  int errors = 0;

  trigger_delay_sweep_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_stop     (cfg_stop),
    .cfg_step     (cfg_step),
    .cfg_repeat   (cfg_repeat),
    .cfg_holdoff  (cfg_holdoff),
    .start        (start),
    .abort        (abort),
    .trig_fired   (trig_fired),
    .delay_cycles (delay_cycles),
    .delay_update (delay_update),
    .busy         (busy),
    .done         (done),
    .cfg_error    (cfg_error),
    .step_index   (step_index)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                     input logic [15:0] r, input logic [15:0] h);
    cfg_start = s; cfg_stop = e; cfg_step = st; cfg_repeat = r; cfg_holdoff = h;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic fire();
    trig_fired = 1'b1; tick(); trig_fired = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; trig_fired = 1'b0;
    cfg(32'd0, 32'd0, 32'd0, 16'd0, 16'd0);
    tick(); tick();
    chk("rst_delay", delay_cycles, 32'd0);
    chk("rst_update", {31'd0, delay_update}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, cfg_error}, 32'd0);
    chk("rst_idx", {16'd0, step_index}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: 100..130 step 10, one fire per step
    cfg(32'd100, 32'd130, 32'd10, 16'd1, 16'd0);
    pulse_start();
    chk("t1_d0", delay_cycles, 32'd100);
    chk("t1_u0", {31'd0, delay_update}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_idx0", {16'd0, step_index}, 32'd1);
    tick();
    chk("t1_u0_drop", {31'd0, delay_update}, 32'd0);
    fire(); chk("t1_d1", delay_cycles, 32'd110); chk("t1_u1", {31'd0, delay_update}, 32'd1);
    fire(); chk("t1_d2", delay_cycles, 32'd120);
    fire(); chk("t1_d3", delay_cycles, 32'd130); chk("t1_u3", {31'd0, delay_update}, 32'd1);
    fire();
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    chk("t1_no_upd", {31'd0, delay_update}, 32'd0);
    chk("t1_d_hold", delay_cycles, 32'd130);
    chk("t1_idx_end", {16'd0, step_index}, 32'd4);
    tick();
    chk("t1_done_drop", {31'd0, done}, 32'd0);

    // 2: single-point sweep, three fires per step
    cfg(32'd5, 32'd5, 32'd1, 16'd3, 16'd0);
    pulse_start();
    chk("t2_d0", delay_cycles, 32'd5);
    fire(); chk("t2_done1", {31'd0, done}, 32'd0); chk("t2_upd1", {31'd0, delay_update}, 32'd0);
    fire(); chk("t2_done2", {31'd0, done}, 32'd0); chk("t2_busy2", {31'd0, busy}, 32'd1);
    fire(); chk("t2_done3", {31'd0, done}, 32'd1); chk("t2_upd3", {31'd0, delay_update}, 32'd0);
    chk("t2_idx", {16'd0, step_index}, 32'd1);

    // 3: step carries out of 32 bits
    cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 16'd1, 16'd0);
    tick();
    pulse_start();
    chk("t3_d0", delay_cycles, 32'hFFFF_FFF0);
    fire();
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_no_upd", {31'd0, delay_update}, 32'd0);
    chk("t3_d_hold", delay_cycles, 32'hFFFF_FFF0);

    // 4: rejected configurations
    tick();
    cfg(32'd1, 32'd10, 32'd0, 16'd1, 16'd0);
    pulse_start();
    chk("t4a_err", {31'd0, cfg_error}, 32'd1);
    chk("t4a_busy", {31'd0, busy}, 32'd0);
    chk("t4a_upd", {31'd0, delay_update}, 32'd0);
    chk("t4a_d", delay_cycles, 32'hFFFF_FFF0);
    tick();
    chk("t4a_err_drop", {31'd0, cfg_error}, 32'd0);
    cfg(32'd50, 32'd40, 32'd1, 16'd1, 16'd0);
    pulse_start();
    chk("t4b_err", {31'd0, cfg_error}, 32'd1);
    chk("t4b_busy", {31'd0, busy}, 32'd0);
    chk("t4b_upd", {31'd0, delay_update}, 32'd0);

    // 5: restart ignored while busy, then abort
    cfg(32'd100, 32'd130, 32'd10, 16'd1, 16'd0);
    pulse_start();
    fire(); fire();
    chk("t5_d2", delay_cycles, 32'd120);
    cfg(32'd7, 32'd9, 32'd1, 16'd1, 16'd0);
    pulse_start();
    chk("t5_restart_d", delay_cycles, 32'd120);
    chk("t5_restart_upd", {31'd0, delay_update}, 32'd0);
    chk("t5_restart_err", {31'd0, cfg_error}, 32'd0);
    chk("t5_restart_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t5_abort_busy", {31'd0, busy}, 32'd0);
    chk("t5_abort_done", {31'd0, done}, 32'd0);
    chk("t5_abort_d", delay_cycles, 32'd120);
    chk("t5_abort_idx", {16'd0, step_index}, 32'd3);
    tick();
    chk("t5_abort_done2", {31'd0, done}, 32'd0);
    // abort together with a fire: fire must not advance the delay
    cfg(32'd100, 32'd130, 32'd10, 16'd1, 16'd0);
    pulse_start();
    abort = 1'b1; trig_fired = 1'b1; tick(); abort = 1'b0; trig_fired = 1'b0;
    chk("t5b_d", delay_cycles, 32'd100);
    chk("t5b_upd", {31'd0, delay_update}, 32'd0);
    chk("t5b_busy", {31'd0, busy}, 32'd0);
    chk("t5b_idx", {16'd0, step_index}, 32'd1);

    // 6: holdoff 4, repeat 2, six back-to-back fires
    cfg(32'd100, 32'd130, 32'd10, 16'd2, 16'd4);
    pulse_start();
    trig_fired = 1'b1;
    tick(); chk("t6_f1_d", delay_cycles, 32'd100); chk("t6_f1_upd", {31'd0, delay_update}, 32'd0);
    tick(); chk("t6_f2_upd", {31'd0, delay_update}, 32'd0);
    tick(); chk("t6_f3_upd", {31'd0, delay_update}, 32'd0);
    tick(); chk("t6_f4_upd", {31'd0, delay_update}, 32'd0);
    tick(); chk("t6_f5_d", delay_cycles, 32'd100); chk("t6_f5_upd", {31'd0, delay_update}, 32'd0);
    tick(); chk("t6_f6_d", delay_cycles, 32'd110); chk("t6_f6_upd", {31'd0, delay_update}, 32'd1);
    chk("t6_f6_idx", {16'd0, step_index}, 32'd2);
    trig_fired = 1'b0;
    rst = 1'b1; tick();
    chk("t6_rst_d", delay_cycles, 32'd0);
    chk("t6_rst_upd", {31'd0, delay_update}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_done", {31'd0, done}, 32'd0);
    chk("t6_rst_idx", {16'd0, step_index}, 32'd0);
    rst = 1'b0;
    tick();
    chk("t6_post_done", {31'd0, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trigger_delay_sweep_ctrl.md
# trigger_delay_sweep_ctrl

Sequencer that automatically sweeps the trigger delay across a programmed range for fault-injection parameter scans. It sits between the UART command FSM and the trigger delay datapath. It drives `delay_cycles`/`delay_update` on the delay module and advances the delay after a programmed number of fired delayed triggers per step. The command FSM loads the sweep configuration, pulses `start`/`abort`, and reads status back.

## Interface
Parameters:
- `DELAY_W`, 32: width of delay values.
- `REPEAT_W`, 16: width of repeat, holdoff and index counters.

Ports (reset rst, synchronous, active-high; clock clk):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `cfg_start` in DELAY_W: first delay value.
- `cfg_stop` in DELAY_W: last permitted delay value, inclusive.
- `cfg_step` in DELAY_W: delay increment per step.
- `cfg_repeat` in REPEAT_W: fired triggers per step. 0 is treated as 1.
- `cfg_holdoff` in REPEAT_W: cycles after each counted fire during which fires are ignored.
- `start` in 1: one-cycle pulse that begins a sweep.
- `abort` in 1: one-cycle pulse that cancels a sweep.
- `trig_fired` in 1: one-cycle pulse, one per delayed trigger output event. Already synchronous to clk.
- `delay_cycles` out DELAY_W: delay value presented to the delay datapath.
- `delay_update` out 1: one-cycle load strobe for `delay_cycles`.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse when the sweep completes normally.
- `cfg_error` out 1: one-cycle pulse when `start` is rejected.
- `step_index` out REPEAT_W: number of delay loads in the current or last sweep.

## Operation
- States: IDLE, ARMED, HOLDOFF.
- Configuration is latched into shadow registers on an accepted `start`. `cfg_*` inputs are ignored at all other times.

IDLE:
- `start` with `cfg_step==0` or `cfg_start>cfg_stop`: pulse `cfg_error`, stay in IDLE, leave outputs unchanged.
- Valid `start`:
  - `delay_cycles<=cfg_start`, `delay_update<=1`.
  - `step_index<=1`, repeat counter `<=0`.
  - Go to ARMED.

ARMED, on `trig_fired`:
- Repeat counter increments.
- If the count has not reached `max(cfg_repeat,1)`: go to HOLDOFF if `cfg_holdoff>0`, else stay in ARMED.
- If the count has reached it: clear the repeat counter, then compute `next = cur + step` at DELAY_W+1 bits.
  - Carry out or `next>stop`: `done<=1`, `busy<=0`, go to IDLE. `delay_cycles` holds the last value; holdoff is skipped.
  - Otherwise: `delay_cycles<=next`, `delay_update<=1`, `step_index++` (wraps modulo 2^REPEAT_W). Go to HOLDOFF if `cfg_holdoff>0`, else stay in ARMED.

HOLDOFF:
- Counter loads `cfg_holdoff` and decrements each cycle.
- `trig_fired` is ignored.
- Return to ARMED in the cycle the counter reaches 0.

Other rules:
- `abort` in ARMED or HOLDOFF: go to IDLE. No `done`, no `delay_update`; `delay_cycles` and `step_index` hold.
- `abort` in IDLE has no effect. `start` and `abort` in the same IDLE cycle: abort wins, start is ignored, no `cfg_error`.
- `start` while `busy` is ignored.
- `abort` and `trig_fired` in the same cycle: abort wins; the fire is not counted.
- `busy` is high exactly while the state is not IDLE.

## Timing
- All outputs are registered.
- Reset values: `delay_cycles=0`, `delay_update=0`, `busy=0`, `done=0`, `cfg_error=0`, `step_index=0`, state IDLE. All internal counters are 0.
- `rst` mid-sweep returns everything to reset values on the next edge. No `done` is emitted.
- `start` sampled at edge k: `delay_cycles`, `delay_update=1` and `busy=1` are visible after edge k (latency 1).
- Final `trig_fired` sampled at edge m: `done=1` and `busy=0` after edge m. `done` drops after edge m+1.
- Advancing `trig_fired` sampled at edge m: new `delay_cycles` with `delay_update=1` after edge m.
- `delay_update`, `done` and `cfg_error` are never high for more than one cycle.
- Holdoff of H: fires sampled at edges m+1 through m+H are ignored. The fire at edge m+H+1 is counted.
- `cfg_error` follows `start` by one cycle.

## Structure
- Shared package / `trigger_delay_defs.vh`:
  - sweep state enum;
  - new command codes `CMD_SWEEP_CFG`, `CMD_SWEEP_START`, `CMD_SWEEP_ABORT`, `CMD_SWEEP_STATUS`;
  - status bit positions (busy, done-latched, error-latched).
- Single module. No sub-module is warranted; the step/overflow compare stays inline.
- The command FSM instantiates this block and muxes its `delay_cycles`/`delay_update` against the manual `CMD_SET_DELAY` path, with the sweep having priority while `busy`.

## Test plan
1. start=100, stop=130, step=10, repeat=1, holdoff=0, then 4 fires:
   - updates 100, 110, 120, 130;
   - `done` one cycle after the 4th fire;
   - `step_index=4`, `busy=0`.
2. start=stop=5, step=1, repeat=3, then 3 fires: single update of 5; `done` after the 3rd fire only.
3. start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x10, repeat=1, then 1 fire: `done`, no second update, `delay_cycles=0xFFFFFFF0`.
4. step=0, start: `cfg_error` pulse, `busy=0`, no `delay_update`. Repeat with start=50, stop=40: same response.
5. Sweep 100..130/10:
   - after 2 fires, a second `start` is ignored;
   - then `abort`: `busy=0` next cycle, no `done`, `delay_cycles=120`.
   - Separately, same-cycle `abort`+`trig_fired`: the fire is not counted.
6. holdoff=4, repeat=2, fires on 6 consecutive cycles: fires 1 and 6 are counted, advancing to the second delay. Then assert `rst` mid-sweep: all outputs return to 0.
